// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone arbiter: round-robin, grant locked for the whole CYC.
// Define WB_ARB_TIMEOUT_EN to enable the watchdog that aborts cycles the slave never acks.
module wb_arbiter_2m #(
  parameter int ADDRESS_LENGTH = 32,
  parameter int DATA_LENGTH    = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m0_cyc,
  input  logic                      m0_stb,
  input  logic                      m0_we,
  input  logic [ADDRESS_LENGTH-1:0] m0_adr,
  input  logic [DATA_LENGTH-1:0]    m0_dat_w,
  output logic [DATA_LENGTH-1:0]    m0_dat_r,
  output logic                      m0_ack,
  output logic                      m0_err,
  input  logic                      m1_cyc,
  input  logic                      m1_stb,
  input  logic                      m1_we,
  input  logic [ADDRESS_LENGTH-1:0] m1_adr,
  input  logic [DATA_LENGTH-1:0]    m1_dat_w,
  output logic [DATA_LENGTH-1:0]    m1_dat_r,
  output logic                      m1_ack,
  output logic                      m1_err,
  output logic                      s_cyc,
  output logic                      s_stb,
  output logic                      s_we,
  output logic [ADDRESS_LENGTH-1:0] s_adr,
  output logic [DATA_LENGTH-1:0]    s_dat_w,
  input  logic [DATA_LENGTH-1:0]    s_dat_r,
  input  logic                      s_ack,
  output logic [1:0]                gnt
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t           state_reg;
  logic             last_reg;
  logic [1:0]       gnt_reg;
  logic             timeout;
  logic             release_now;
  logic [1:0]       cyc_vec;
  logic [1:0]       ack_vec;
  logic [1:0]       err_vec;
  logic [DATA_LENGTH-1:0] dat_r_vec [2];

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  assign cyc_vec     = {m1_cyc, m0_cyc};
  assign release_now = |(gnt_reg & ~cyc_vec);
  assign gnt         = gnt_reg;

  // Slave side follows the owner; gating by gnt keeps the port quiet in IDLE.
  assign s_cyc   = (gnt_reg[0] & m0_cyc) | (gnt_reg[1] & m1_cyc);
  assign s_stb   = (gnt_reg[0] & m0_stb) | (gnt_reg[1] & m1_stb);
  assign s_we    = (gnt_reg[0] & m0_we)  | (gnt_reg[1] & m1_we);
  assign s_adr   = gnt_reg[0] ? m0_adr   : (gnt_reg[1] ? m1_adr   : '0);
  assign s_dat_w = gnt_reg[0] ? m0_dat_w : (gnt_reg[1] ? m1_dat_w : '0);

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign ack_vec[gi]   = gnt_reg[gi] & s_ack;
    assign err_vec[gi]   = gnt_reg[gi] & timeout;
    assign dat_r_vec[gi] = gnt_reg[gi] ? s_dat_r : '0;
  end

  assign m0_ack   = ack_vec[0];
  assign m1_ack   = ack_vec[1];
  assign m0_err   = err_vec[0];
  assign m1_err   = err_vec[1];
  assign m0_dat_r = dat_r_vec[0];
  assign m1_dat_r = dat_r_vec[1];

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wdog_reg;

  // An ack in the limit cycle wins over the abort.
  assign timeout = (state_reg != IDLE) && s_stb && !s_ack &&
                   (wdog_reg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_reg <= '0;
    end else if (state_reg == IDLE || s_ack || timeout || release_now) begin
      wdog_reg <= '0;
    end else if (s_stb) begin
      wdog_reg <= wdog_reg + CW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      gnt_reg   <= 2'b00;
      last_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          // On a tie, serve whoever did not go last.
          if (m0_cyc && (!m1_cyc || last_reg)) begin
            state_reg <= GNT0;
            gnt_reg   <= 2'b01;
            last_reg  <= 1'b0;
          end else if (m1_cyc) begin
            state_reg <= GNT1;
            gnt_reg   <= 2'b10;
            last_reg  <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (release_now || timeout) begin
            state_reg <= IDLE;
            gnt_reg   <= 2'b00;
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed self-checking bench for wb_arbiter_2m; inputs change just after the
// rising edge, outputs are sampled on the falling edge.
module tb_wb_arbiter_2m;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_cyc, m0_stb, m0_we;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_dat_w, m0_dat_r;
  logic          m0_ack, m0_err;
  logic          m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_dat_w, m1_dat_r;
  logic          m1_ack, m1_err;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_w, s_dat_r;
  logic          s_ack;
  logic [1:0]    gnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m #(
    .ADDRESS_LENGTH(AW),
    .DATA_LENGTH(DW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack), .gnt(gnt)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_w = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_w = '0;
    s_ack = 0; s_dat_r = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1;
    next_cycle();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    next_cycle();
    next_cycle();
    reset = 0;
    // Slave drives junk: nothing may leak through while idle.
    s_dat_r = 32'hA5A5_A5A5;
    s_ack   = 1;
    for (int i = 0; i < 5; i++) begin
      sample();
      vectors++;
      if ({gnt, s_cyc, s_stb, s_we, m0_ack, m1_ack, m0_err, m1_err} !== 9'd0 ||
          s_adr !== '0 || s_dat_w !== '0 || m0_dat_r !== '0 || m1_dat_r !== '0) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: gnt=%b cyc=%b stb=%b we=%b ack=%b%b err=%b%b adr=%h dw=%h dr0=%h dr1=%h want all 0",
                 i, gnt, s_cyc, s_stb, s_we, m0_ack, m1_ack, m0_err, m1_err,
                 s_adr, s_dat_w, m0_dat_r, m1_dat_r);
      end
      next_cycle();
    end
    clear_inputs();
    $display("reset: idle for 5 cycles after reset");
  endtask

  task automatic test_single_read();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h0000_0040;
    sample();
    vectors++;
    if (gnt !== 2'b00) begin miscompares++; $display("FAIL read_req_gnt: got %b want 00", gnt); end
    next_cycle();
    sample();
    vectors++;
    if ({gnt, s_cyc, m0_ack} !== 4'b0110 || s_adr !== 32'h40) begin
      miscompares++;
      $display("FAIL read_grant: gnt=%b s_cyc=%b m0_ack=%b s_adr=%h want 01 1 0 00000040", gnt, s_cyc, m0_ack, s_adr);
    end
    next_cycle();
    s_ack = 1; s_dat_r = 32'hDEAD_BEEF;
    sample();
    vectors++;
    if ({m0_ack, m1_ack} !== 2'b10 || m0_dat_r !== 32'hDEAD_BEEF || m1_dat_r !== '0) begin
      miscompares++;
      $display("FAIL read_ack: m0_ack=%b m1_ack=%b m0_dat_r=%h m1_dat_r=%h want 1 0 deadbeef 0", m0_ack, m1_ack, m0_dat_r, m1_dat_r);
    end
    next_cycle();
    m0_cyc = 0; m0_stb = 0; s_ack = 0; s_dat_r = '0;
    sample();
    vectors++;
    if ({gnt, s_cyc} !== 3'b010) begin
      miscompares++;
      $display("FAIL read_cyc_drop: gnt=%b s_cyc=%b want 01 0", gnt, s_cyc);
    end
    next_cycle();
    sample();
    vectors++;
    if (gnt !== 2'b00) begin miscompares++; $display("FAIL read_release: got %b want 00", gnt); end
    next_cycle();
    $display("single_read: m0 adr=00000040 data=deadbeef");
  endtask

  task automatic test_simultaneous();
    apply_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h200;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h100; m1_dat_w = 32'h1234_5678;
    next_cycle();
    s_ack = 1; s_dat_r = 32'h0000_0011;
    sample();
    vectors++;
    if ({gnt, s_we, m0_ack, m1_ack} !== 5'b01010) begin
      miscompares++;
      $display("FAIL sim_first: gnt=%b s_we=%b m0_ack=%b m1_ack=%b want 01 0 1 0", gnt, s_we, m0_ack, m1_ack);
    end
    next_cycle();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    next_cycle();
    sample();
    vectors++;
    if ({gnt, s_cyc} !== 3'b000) begin
      miscompares++;
      $display("FAIL sim_gap: gnt=%b s_cyc=%b want 00 0", gnt, s_cyc);
    end
    next_cycle();
    s_ack = 1;
    sample();
    vectors++;
    if ({gnt, s_we, m1_ack, m0_ack} !== 5'b10110 || s_dat_w !== 32'h1234_5678 || s_adr !== 32'h100) begin
      miscompares++;
      $display("FAIL sim_second: gnt=%b s_we=%b m1_ack=%b m0_ack=%b s_dat_w=%h s_adr=%h want 10 1 1 0 12345678 00000100",
               gnt, s_we, m1_ack, m0_ack, s_dat_w, s_adr);
    end
    next_cycle();
    clear_inputs();
    next_cycle();
    $display("simultaneous: m0 read then m1 write 12345678 to 00000100");
  endtask

  task automatic test_fairness();
    logic [1:0] exp_gnt;
    for (int i = 0; i < 6; i++) begin
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h1000;
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h2000;
      next_cycle();
      s_ack = 1;
      sample();
      vectors++;
      if (gnt !== exp_gnt || {m1_ack, m0_ack} !== exp_gnt) begin
        miscompares++;
        $display("FAIL fair[%0d]: gnt=%b acks=%b%b want %b", i, gnt, m1_ack, m0_ack, exp_gnt);
      end
      next_cycle();
      s_ack = 0;
      if (exp_gnt[0]) begin m0_cyc = 0; m0_stb = 0; end
      else begin m1_cyc = 0; m1_stb = 0; end
      next_cycle();
      $display("fairness: transaction %0d expected grant %b", i, exp_gnt);
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_lock_and_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h300;
    next_cycle();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h400;
    sample();
    vectors++;
    if (gnt !== 2'b10) begin miscompares++; $display("FAIL lock_grant: got %b want 10", gnt); end
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      s_ack = 1; s_dat_r = 32'hC0DE_0000 + k;
      sample();
      vectors++;
      if ({gnt, m1_ack, m0_ack} !== 4'b1010 || m1_dat_r !== 32'hC0DE_0000 + k || m0_dat_r !== '0) begin
        miscompares++;
        $display("FAIL lock_beat[%0d]: gnt=%b m1_ack=%b m0_ack=%b m1_dat_r=%h m0_dat_r=%h want 10 1 0 %h 0",
                 k, gnt, m1_ack, m0_ack, m1_dat_r, m0_dat_r, 32'hC0DE_0000 + k);
      end
      next_cycle();
      s_ack = 0;
      sample();
      vectors++;
      if ({gnt, m0_ack} !== 3'b100) begin
        miscompares++;
        $display("FAIL lock_wait[%0d]: gnt=%b m0_ack=%b want 10 0", k, gnt, m0_ack);
      end
      next_cycle();
    end
    s_ack = 1; reset = 1;
    sample();
    vectors++;
    if (gnt !== 2'b10) begin miscompares++; $display("FAIL reset_beat: gnt=%b want 10", gnt); end
    next_cycle();
    sample();
    vectors++;
    if ({gnt, s_cyc, m0_ack, m1_ack} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_drop: gnt=%b s_cyc=%b m0_ack=%b m1_ack=%b want 00 0 0 0", gnt, s_cyc, m0_ack, m1_ack);
    end
    reset = 0;
    clear_inputs();
    next_cycle();
    $display("lock: m1 held 3 beats, reset mid-beat");
  endtask

  task automatic test_timeout();
    apply_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h500;
    next_cycle();
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      sample();
      vectors++;
      if ({gnt, m0_err, m0_ack, m1_err} !== {2'b01, (i == 7), 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL timeout[%0d]: gnt=%b m0_err=%b m0_ack=%b m1_err=%b want 01 %0d 0 0",
                 i, gnt, m0_err, m0_ack, m1_err, (i == 7));
      end
      next_cycle();
    end
    sample();
    vectors++;
    if ({gnt, s_cyc, m0_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL timeout_abort: gnt=%b s_cyc=%b m0_err=%b want 00 0 0", gnt, s_cyc, m0_err);
    end
    $display("timeout: m0 aborted after 8 unacked strobe cycles");
`else
    for (int i = 0; i < 20; i++) begin
      sample();
      vectors++;
      if ({gnt, m0_err, m1_err, s_cyc} !== 5'b01001) begin
        miscompares++;
        $display("FAIL hold[%0d]: gnt=%b m0_err=%b m1_err=%b s_cyc=%b want 01 0 0 1",
                 i, gnt, m0_err, m1_err, s_cyc);
      end
      next_cycle();
    end
    $display("timeout: watchdog absent, m0 grant held 20 cycles");
`endif
    clear_inputs();
    next_cycle();
    next_cycle();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fairness();
    test_lock_and_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
